pager612_ctrl: RTL and testbench

- Sequencer and arbiter in front of the 16 x 12-bit page-register file (74LS612-style pager).
- After reset it loads every page register with a default mapping.
- It then shares register read/write access between the CPU bus decoder and the host/loader port, using two-way round-robin.
- It owns the pager's access_regs, write_enable, page_reg_read, abus_low, dbus_in and mapen controls.

---
 rtl/pager612_ctrl_pkg.sv | 19 +
 rtl/pager612_ctrl_if.sv | 16 +
 rtl/pager612_ctrl_arb.sv | 34 +++
 rtl/pager612_ctrl.sv | 147 ++++++++++++++
 tb/tb_pager612_ctrl.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pager612_ctrl_pkg.sv
// Shared types and sizes for the 74LS612-style pager sequencer/arbiter.
package pager612_ctrl_pkg;

  localparam int NUM_PAGE_REGS = 16;
  localparam int PAGE_IDX_W    = 4;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  typedef enum logic {
    GNT_CPU  = 1'b0,
    GNT_HOST = 1'b1
  } gnt_t;

endpackage

// File: rtl/pager612_ctrl_if.sv
// Register-access request port; one instance each for the CPU decoder and the host/loader.
interface pager612_ctrl_if
  import pager612_ctrl_pkg::*;
#(
  parameter int DATA_W = 12
);
  logic                  req;
  logic                  we;
  logic [PAGE_IDX_W-1:0] idx;
  logic [DATA_W-1:0]     wdata;
  logic                  ack;
  logic [DATA_W-1:0]     rdata;

  modport master (output req, we, idx, wdata, input ack, rdata);
  modport slave  (input req, we, idx, wdata, output ack, rdata);
endinterface

// File: rtl/pager612_ctrl_arb.sv
// Two-way round-robin arbiter: a tie goes to the requester that did not win last time.
module pager612_ctrl_arb
  import pager612_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req_cpu_i,
  input  logic req_host_i,
  input  logic take_i,
  output logic gnt_valid_o,
  output gnt_t gnt_sel_o
);
  gnt_t last_q;

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    gnt_valid_o = req_cpu_i | req_host_i;
    gnt_sel_o   = GNT_CPU;
    if (req_cpu_i && req_host_i) begin
      gnt_sel_o = (last_q == GNT_HOST) ? GNT_CPU : GNT_HOST;
    end else if (req_host_i) begin
      gnt_sel_o = GNT_HOST;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= GNT_HOST;
    end else if (take_i && gnt_valid_o) begin
      last_q <= gnt_sel_o;
    end
  end
endmodule

// File: rtl/pager612_ctrl.sv
// Pager sequencer: loads default page mappings after reset, then arbitrates CPU/host register access.
module pager612_ctrl
  import pager612_ctrl_pkg::*;
#(
  parameter int                DATA_W    = 12,
  parameter logic [DATA_W-1:0] INIT_BASE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  pager612_ctrl_if.slave        cpu_bus,
  pager612_ctrl_if.slave        host_bus,
  input  logic                  map_cfg_i,
  input  logic                  reinit_i,
  output logic                  busy_o,
  output logic                  pg_access_regs_o,
  output logic                  pg_write_enable_o,
  output logic                  pg_reg_read_o,
  output logic [PAGE_IDX_W-1:0] pg_abus_low_o,
  output logic [DATA_W-1:0]     pg_dbus_in_o,
  input  logic [DATA_W-1:0]     pg_dbus_out_i,
  output logic                  pg_mapen_o,
  output logic                  xlat_valid_o
);
  state_t                state_q, state_d;
  logic [PAGE_IDX_W-1:0] cnt_q, cnt_d, idx_q, idx_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d, rdata_q, rdata_d;
  logic                  we_q, we_d, pending_q, pending_d, started_q, mapen_q;
  gnt_t                  gnt_q, gnt_d, gnt_sel;
  logic                  gnt_valid, take;

  pager612_ctrl_arb u_arb (
    .clk         (clk),
    .reset       (reset),
    .req_cpu_i   (cpu_bus.req),
    .req_host_i  (host_bus.req),
    .take_i      (take),
    .gnt_valid_o (gnt_valid),
    .gnt_sel_o   (gnt_sel)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    we_d      = we_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    gnt_d     = gnt_q;
    rdata_d   = rdata_q;
    take      = 1'b0;
    case (state_q)
      ST_INIT: begin
        // The counter holds for the first cycle out of reset so index 0 is written after release.
        if (reinit_i) begin
          cnt_d = '0;
        end else if (started_q) begin
          cnt_d = cnt_q + PAGE_IDX_W'(1);
          if (cnt_q == '1) state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (reinit_i || pending_q) begin
          state_d   = ST_INIT;
          cnt_d     = '0;
          pending_d = 1'b0;
        end else if (gnt_valid) begin
          take    = 1'b1;
          gnt_d   = gnt_sel;
          state_d = ST_ACCESS;
          if (gnt_sel == GNT_CPU) begin
            we_d    = cpu_bus.we;
            idx_d   = cpu_bus.idx;
            wdata_d = cpu_bus.wdata;
          end else begin
            we_d    = host_bus.we;
            idx_d   = host_bus.idx;
            wdata_d = host_bus.wdata;
          end
        end
      end
      ST_ACCESS: begin
        if (reinit_i) pending_d = 1'b1;
        if (!we_q) rdata_d = pg_dbus_out_i;
        state_d = ST_DONE;
      end
      default: begin
        if (reinit_i) pending_d = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_INIT;
      cnt_q     <= '0;
      started_q <= 1'b0;
      pending_q <= 1'b0;
      we_q      <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      gnt_q     <= GNT_CPU;
      rdata_q   <= '0;
      mapen_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      started_q <= 1'b1;
      pending_q <= pending_d;
      we_q      <= we_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
      gnt_q     <= gnt_d;
      rdata_q   <= rdata_d;
      mapen_q   <= map_cfg_i && (state_d != ST_INIT);
    end
  end

  // Pager strobes decode only registered state, so requests never reach the pager combinationally.
  always_comb begin
    pg_access_regs_o  = 1'b0;
    pg_write_enable_o = 1'b0;
    pg_reg_read_o     = 1'b0;
    pg_abus_low_o     = '0;
    pg_dbus_in_o      = '0;
    if (state_q == ST_INIT && started_q) begin
      pg_access_regs_o  = 1'b1;
      pg_write_enable_o = 1'b1;
      pg_abus_low_o     = cnt_q;
      pg_dbus_in_o      = INIT_BASE + DATA_W'(cnt_q);
    end else if (state_q == ST_ACCESS) begin
      pg_access_regs_o  = 1'b1;
      pg_abus_low_o     = idx_q;
      pg_write_enable_o = we_q;
      pg_reg_read_o     = !we_q;
      pg_dbus_in_o      = we_q ? wdata_q : '0;
    end
  end

  assign busy_o         = (state_q != ST_IDLE);
  assign xlat_valid_o   = !pg_access_regs_o;
  assign pg_mapen_o     = mapen_q;
  assign cpu_bus.ack    = (state_q == ST_DONE) && (gnt_q == GNT_CPU);
  assign host_bus.ack   = (state_q == ST_DONE) && (gnt_q == GNT_HOST);
  assign cpu_bus.rdata  = rdata_q;
  assign host_bus.rdata = rdata_q;
endmodule

// File: tb/tb_pager612_ctrl.sv
// Directed bench for pager612_ctrl with a behavioural 16-entry page-register file behind it.
module tb_pager612_ctrl;
  import pager612_ctrl_pkg::*;

  localparam int DATA_W = 12;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic map_cfg = 1'b1;
  logic reinit = 1'b0;
  always #5 clk = ~clk;

  pager612_ctrl_if #(.DATA_W(DATA_W)) cpu_bus ();
  pager612_ctrl_if #(.DATA_W(DATA_W)) host_bus ();
  pager612_ctrl_if #(.DATA_W(DATA_W)) cpu2_bus ();
  pager612_ctrl_if #(.DATA_W(DATA_W)) host2_bus ();

  logic              busy, access, wen, rd, mapen, xlat;
  logic [3:0]        abus;
  logic [DATA_W-1:0] dbus_in, dbus_out;
  logic              busy2, access2, wen2, rd2, mapen2, xlat2;
  logic [3:0]        abus2;
  logic [DATA_W-1:0] dbus_in2, dbus_out2;

  logic [DATA_W-1:0] mem  [NUM_PAGE_REGS];
  logic [DATA_W-1:0] mem2 [NUM_PAGE_REGS];

  always @(posedge clk) if (access && wen) mem[abus] <= dbus_in;
  always @(posedge clk) if (access2 && wen2) mem2[abus2] <= dbus_in2;
  assign dbus_out  = mem[abus];
  assign dbus_out2 = mem2[abus2];

  pager612_ctrl #(.DATA_W(DATA_W), .INIT_BASE(12'h000)) u_dut (
    .clk(clk), .reset(reset), .cpu_bus(cpu_bus), .host_bus(host_bus),
    .map_cfg_i(map_cfg), .reinit_i(reinit), .busy_o(busy),
    .pg_access_regs_o(access), .pg_write_enable_o(wen), .pg_reg_read_o(rd),
    .pg_abus_low_o(abus), .pg_dbus_in_o(dbus_in), .pg_dbus_out_i(dbus_out),
    .pg_mapen_o(mapen), .xlat_valid_o(xlat)
  );

  pager612_ctrl #(.DATA_W(DATA_W), .INIT_BASE(12'h100)) u_dut2 (
    .clk(clk), .reset(reset), .cpu_bus(cpu2_bus), .host_bus(host2_bus),
    .map_cfg_i(map_cfg), .reinit_i(1'b0), .busy_o(busy2),
    .pg_access_regs_o(access2), .pg_write_enable_o(wen2), .pg_reg_read_o(rd2),
    .pg_abus_low_o(abus2), .pg_dbus_in_o(dbus_in2), .pg_dbus_out_i(dbus_out2),
    .pg_mapen_o(mapen2), .xlat_valid_o(xlat2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One complete transaction; ends one cycle after the ack so the controller is back in IDLE.
  task automatic access_txn(input bit host, input bit wr, input logic [3:0] idx,
                            input logic [DATA_W-1:0] wd, output logic [DATA_W-1:0] rdv,
                            output bit got);
    got = 1'b0;
    rdv = '0;
    if (host) begin
      host_bus.we = wr; host_bus.idx = idx; host_bus.wdata = wd; host_bus.req = 1'b1;
    end else begin
      cpu_bus.we = wr; cpu_bus.idx = idx; cpu_bus.wdata = wd; cpu_bus.req = 1'b1;
    end
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge clk);
      if (host && host_bus.ack === 1'b1) begin got = 1'b1; rdv = host_bus.rdata; end
      if (!host && cpu_bus.ack === 1'b1) begin got = 1'b1; rdv = cpu_bus.rdata; end
    end
    cpu_bus.req  = 1'b0;
    host_bus.req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    cyc(2);
    n_checks++;
    if ({busy, cpu_bus.ack, host_bus.ack, wen, rd, mapen} !== 6'b100000 || cpu_bus.rdata !== '0) begin
      n_fail++;
      $display("FAIL reset_values: busy/acks/we/rd/mapen=%b rdata=%h, expected 100000 rdata=000",
               {busy, cpu_bus.ack, host_bus.ack, wen, rd, mapen}, cpu_bus.rdata);
    end
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      n_checks++;
      if ({busy, access, wen, mapen, abus, dbus_in} !== {4'b1110, 4'(i), DATA_W'(i)}) begin
        n_fail++;
        $display("FAIL init_cycle_%0d: busy/acc/we/mapen=%b abus=%0d dbus=%h, expected 1110 abus=%0d dbus=%h",
                 i, {busy, access, wen, mapen}, abus, dbus_in, i, DATA_W'(i));
      end
    end
    @(negedge clk);
    n_checks++;
    if ({busy, mapen, xlat, access} !== 4'b0110) begin
      n_fail++;
      $display("FAIL init_exit: busy/mapen/xlat/acc=%b, expected 0110", {busy, mapen, xlat, access});
    end
    n_checks++;
    if (mem2[15] !== 12'h10F || mem2[0] !== 12'h100) begin
      n_fail++;
      $display("FAIL init_base_100: reg0=%h reg15=%h, expected 100 10f", mem2[0], mem2[15]);
    end
  endtask

  task automatic test_back_to_back();
    int order[4];
    int n = 0;
    cpu_bus.we = 1'b0;  cpu_bus.idx = 4'd1;
    host_bus.we = 1'b0; host_bus.idx = 4'd4;
    for (int r = 0; r < 2; r++) begin
      cpu_bus.req  = 1'b1;
      host_bus.req = 1'b1;
      for (int c = 0; c < 20 && (cpu_bus.req || host_bus.req); c++) begin
        @(negedge clk);
        if (cpu_bus.ack === 1'b1) begin
          n_checks++;
          if (!cpu_bus.req) begin n_fail++; $display("FAIL arb_cpu_pulse: ack=1 after req dropped, expected 0"); end
          if (n < 4) order[n] = 0;
          n++;
          cpu_bus.req = 1'b0;
        end
        if (host_bus.ack === 1'b1) begin
          n_checks++;
          if (!host_bus.req) begin n_fail++; $display("FAIL arb_host_pulse: ack=1 after req dropped, expected 0"); end
          if (n < 4) order[n] = 1;
          n++;
          host_bus.req = 1'b0;
        end
      end
      cpu_bus.req  = 1'b0;
      host_bus.req = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({cpu_bus.ack, host_bus.ack} !== 2'b00) begin
        n_fail++;
        $display("FAIL arb_ack_width: acks=%b one cycle later, expected 00", {cpu_bus.ack, host_bus.ack});
      end
    end
    n_checks++;
    if (n != 4) begin n_fail++; $display("FAIL arb_grant_count: got %0d, expected 4", n); end
    for (int i = 0; i < 4 && i < n; i++) begin
      n_checks++;
      if (order[i] != (i % 2)) begin
        n_fail++;
        $display("FAIL arb_order_%0d: granted %s, expected %s", i,
                 order[i] == 0 ? "cpu" : "host", (i % 2) == 0 ? "cpu" : "host");
      end
    end
  endtask

  task automatic test_cpu_write_read();
    logic [DATA_W-1:0] rv;
    bit got;
    access_txn(1'b0, 1'b0, 4'd5, '0, rv, got);
    n_checks++;
    if (!got || rv !== 12'h005) begin n_fail++; $display("FAIL read_idx5: got=%0b rdata=%h, expected 1 005", got, rv); end
    cpu_bus.we = 1'b1; cpu_bus.idx = 4'd3; cpu_bus.wdata = 12'hABC; cpu_bus.req = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({access, wen, rd, xlat, cpu_bus.ack} !== 5'b11000 || abus !== 4'd3 || dbus_in !== 12'hABC) begin
      n_fail++;
      $display("FAIL wr_access: acc/we/rd/xlat/ack=%b abus=%0d dbus=%h, expected 11000 3 abc",
               {access, wen, rd, xlat, cpu_bus.ack}, abus, dbus_in);
    end
    @(negedge clk);
    n_checks++;
    if ({cpu_bus.ack, host_bus.ack, xlat, wen} !== 4'b1010) begin
      n_fail++;
      $display("FAIL wr_done: cpu_ack/host_ack/xlat/we=%b, expected 1010", {cpu_bus.ack, host_bus.ack, xlat, wen});
    end
    cpu_bus.req = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({cpu_bus.ack, busy, xlat} !== 3'b001) begin
      n_fail++;
      $display("FAIL wr_after: ack/busy/xlat=%b, expected 001", {cpu_bus.ack, busy, xlat});
    end
    access_txn(1'b0, 1'b0, 4'd3, '0, rv, got);
    n_checks++;
    if (!got || rv !== 12'hABC) begin n_fail++; $display("FAIL read_idx3: got=%0b rdata=%h, expected 1 abc", got, rv); end
  endtask

  task automatic test_reinit_during_access();
    logic [DATA_W-1:0] rv;
    bit got;
    host_bus.we = 1'b1; host_bus.idx = 4'd2; host_bus.wdata = 12'h777; host_bus.req = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({access, wen} !== 2'b11 || abus !== 4'd2) begin
      n_fail++;
      $display("FAIL reinit_access: acc/we=%b abus=%0d, expected 11 2", {access, wen}, abus);
    end
    reinit = 1'b1;
    @(negedge clk);
    reinit = 1'b0;
    n_checks++;
    if (host_bus.ack !== 1'b1 || mem[2] !== 12'h777) begin
      n_fail++;
      $display("FAIL reinit_ack: host_ack=%b reg2=%h, expected 1 777", host_bus.ack, mem[2]);
    end
    host_bus.req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reinit_idle_gap: busy=%b, expected 0", busy); end
    @(negedge clk);
    n_checks++;
    if ({busy, wen} !== 2'b11 || abus !== 4'd0) begin
      n_fail++;
      $display("FAIL reinit_start: busy/we=%b abus=%0d, expected 11 0", {busy, wen}, abus);
    end
    cyc(16);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reinit_end: busy=%b, expected 0", busy); end
    access_txn(1'b0, 1'b0, 4'd2, '0, rv, got);
    n_checks++;
    if (!got || rv !== 12'h002) begin n_fail++; $display("FAIL reinit_read_idx2: got=%0b rdata=%h, expected 1 002", got, rv); end
  endtask

  task automatic test_reset_mid();
    logic [DATA_W-1:0] rv;
    bit got, found, any_ack;
    reinit = 1'b1;
    @(negedge clk);
    reinit = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (wen === 1'b1 && abus === 4'd7) begin found = 1'b1; break; end
      @(negedge clk);
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL mid_init_reach7: found=0, expected 1"); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if ({busy, wen} !== 2'b10) begin n_fail++; $display("FAIL mid_init_reset: busy/we=%b, expected 10", {busy, wen}); end
    @(negedge clk);
    n_checks++;
    if ({busy, wen} !== 2'b11 || abus !== 4'd0) begin
      n_fail++;
      $display("FAIL mid_init_restart: busy/we=%b abus=%0d, expected 11 0", {busy, wen}, abus);
    end
    cyc(16);
    access_txn(1'b0, 1'b1, 4'd9, 12'h555, rv, got);
    n_checks++;
    if (!got || mem[9] !== 12'h555) begin n_fail++; $display("FAIL mid_wr_idx9: got=%0b reg9=%h, expected 1 555", got, mem[9]); end
    cpu_bus.we = 1'b0; cpu_bus.idx = 4'd9; cpu_bus.req = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({access, rd} !== 2'b11) begin n_fail++; $display("FAIL mid_rd_access: acc/rd=%b, expected 11", {access, rd}); end
    reset = 1'b1;
    cpu_bus.req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    any_ack = 1'b0;
    for (int c = 0; c < 18; c++) begin
      if (cpu_bus.ack === 1'b1 || host_bus.ack === 1'b1) any_ack = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (any_ack || busy !== 1'b0 || cpu_bus.rdata !== '0) begin
      n_fail++;
      $display("FAIL mid_rd_dropped: ack_seen=%b busy=%b rdata=%h, expected 0 0 000", any_ack, busy, cpu_bus.rdata);
    end
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (mem[i] !== DATA_W'(i)) begin
        n_fail++;
        $display("FAIL mid_reg_%0d: value=%h, expected %h", i, mem[i], DATA_W'(i));
      end
    end
  endtask

  initial begin
    cpu_bus.req = 1'b0;   cpu_bus.we = 1'b0;   cpu_bus.idx = '0;   cpu_bus.wdata = '0;
    host_bus.req = 1'b0;  host_bus.we = 1'b0;  host_bus.idx = '0;  host_bus.wdata = '0;
    cpu2_bus.req = 1'b0;  cpu2_bus.we = 1'b0;  cpu2_bus.idx = '0;  cpu2_bus.wdata = '0;
    host2_bus.req = 1'b0; host2_bus.we = 1'b0; host2_bus.idx = '0; host2_bus.wdata = '0;
    test_reset();
    test_back_to_back();
    test_cpu_write_read();
    test_reinit_during_access();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
